// File: rtl/mul_arbiter.sv
// mul_arbiter: two requesters share one 8x8 unsigned shift-add multiplier, round-robin arbitrated
//   clk            rising-edge clock
//   reset          synchronous, active-high
//   req0/a0/b0     requester 0 level request and operands
//   req1/a1/b1     requester 1 level request and operands
//   gnt0/gnt1      one-cycle pulse: that requester's operands were captured
//   done0/done1    one-cycle pulse: result holds that requester's product
//   result         last completed product
//   busy           high whenever not idle
module mul_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic [7:0]  a0,
   input  logic [7:0]  b0,
   input  logic        req1,
   input  logic [7:0]  a1,
   input  logic [7:0]  b1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic [15:0] result,
   output logic        busy
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   logic [1:0]  r_state;
   logic [2:0]  r_cnt;
   logic [15:0] r_acc;
   logic [15:0] r_mcand;
   logic [7:0]  r_mplier;
   logic        r_last;
   logic        w_win;
   logic        w_start;
   logic [15:0] w_acc_next;
   // requester 1 wins when alone, or on a tie when requester 0 was served last
   assign w_win      = (req0 && req1) ? ~r_last : req1;
   // the DONE cycle may grant directly so back-to-back products take 9 cycles each
   assign w_start    = (req0 || req1) && (r_state == S_IDLE || r_state == S_DONE);
   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : 16'd0);
   assign busy       = (r_state != S_IDLE);
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= 3'd0;
         r_acc    <= 16'd0;
         r_mcand  <= 16'd0;
         r_mplier <= 8'd0;
         r_last   <= 1'b1;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         result   <= 16'd0;
      end else begin
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         if (w_start) begin
            r_state  <= S_MUL;
            r_cnt    <= 3'd0;
            r_acc    <= 16'd0;
            r_mcand  <= {8'd0, w_win ? a1 : a0};
            r_mplier <= w_win ? b1 : b0;
            r_last   <= w_win;
            gnt0     <= ~w_win;
            gnt1     <= w_win;
         end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
               r_state <= S_DONE;
               result  <= w_acc_next;
               done0   <= ~r_last;
               done1   <= r_last;
            end
         end else begin
            r_state <= S_IDLE;
         end
      end
   end
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: table, random and corner-case checks of mul_arbiter against a product/round-robin model
module tb_mul_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req0 = 1'b0;
   logic        req1 = 1'b0;
   logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic        gnt0, gnt1, done0, done1, busy;
   logic [15:0] result;
   int          errors = 0;
   int          checks = 0;
   int          last_srv = 1;
   logic        mon_en = 1'b0;

   typedef struct {
      logic        r0, r1;
      logic [7:0]  x0, y0, x1, y1;
      int          ew;
      logic [15:0] ep;
   } vec_t;
   vec_t tbl[8];

   always #5 clk = ~clk;

   mul_arbiter dut (
      .clk(clk), .reset(reset),
      .req0(req0), .a0(a0), .b0(b0),
      .req1(req1), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .result(result), .busy(busy)
   );

   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if ((gnt0 && gnt1) || (done0 && done1)) begin
            errors++;
            $display("FAIL exclusive pulses: gnt=%b%b done=%b%b required at most one each", gnt1, gnt0, done1, done0);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      req0  = 1'b0;
      req1  = 1'b0;
      tick;
      reset = 1'b0;
      last_srv = 1;
   endtask

   function automatic int pick(input logic r0, input logic r1);
      int w;
      w = (r0 && r1) ? 1 - last_srv : (r1 ? 1 : 0);
      last_srv = w;
      return w;
   endfunction

   task automatic run_op(input logic r0, input logic r1, input logic [7:0] x0, input logic [7:0] y0,
                         input logic [7:0] x1, input logic [7:0] y1, input int ew, input logic [15:0] ep,
                         input string nm);
      int stray;
      req0 = r0; req1 = r1; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
      tick;
      req0 = 1'b0; req1 = 1'b0;
      chk({nm, " gnt0"}, gnt0, ew == 0);
      chk({nm, " gnt1"}, gnt1, ew == 1);
      chk({nm, " busy@gnt"}, busy, 1);
      a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
      stray = 0;
      for (int i = 1; i < 8; i++) begin
         tick;
         if (gnt0 || gnt1 || done0 || done1 || !busy) stray++;
      end
      chk({nm, " mul quiet"}, stray, 0);
      tick;
      chk({nm, " done0"}, done0, ew == 0);
      chk({nm, " done1"}, done1, ew == 1);
      chk({nm, " result"}, result, ep);
      chk({nm, " busy@done"}, busy, 1);
      tick;
      chk({nm, " idle busy"}, busy, 0);
      chk({nm, " idle done"}, done0 | done1, 0);
      chk({nm, " result hold"}, result, ep);
   endtask

   initial begin
      int seen, cnt, w, r;
      logic [7:0] x0, y0, x1, y1;
      int gcyc[$], gwho[$], dres[$];
      tbl[0] = '{1'b1, 1'b0, 8'd20,  8'd23,  8'd0,   8'd0,   0, 16'h01CC};
      tbl[1] = '{1'b0, 1'b1, 8'd0,   8'd0,   8'd255, 8'd255, 1, 16'hFE01};
      tbl[2] = '{1'b1, 1'b0, 8'd0,   8'd200, 8'd0,   8'd0,   0, 16'h0000};
      tbl[3] = '{1'b1, 1'b1, 8'd3,   8'd4,   8'd5,   8'd6,   1, 16'd30};
      tbl[4] = '{1'b1, 1'b1, 8'd3,   8'd4,   8'd5,   8'd6,   0, 16'd12};
      tbl[5] = '{1'b0, 1'b1, 8'd9,   8'd9,   8'd1,   8'd1,   1, 16'd1};
      tbl[6] = '{1'b1, 1'b0, 8'd255, 8'd1,   8'd0,   8'd0,   0, 16'd255};
      tbl[7] = '{1'b1, 1'b1, 8'd16,  8'd16,  8'd128, 8'd2,   1, 16'd256};

      // reset state and reset priority over a pending request
      do_reset;
      mon_en = 1'b1;
      chk("rst gnt", {gnt1, gnt0}, 0);
      chk("rst done", {done1, done0}, 0);
      chk("rst busy", busy, 0);
      chk("rst result", result, 0);
      reset = 1'b1; req0 = 1'b1; a0 = 8'd5; b0 = 8'd5;
      tick;
      chk("rst prio gnt0", gnt0, 0);
      chk("rst prio busy", busy, 0);
      do_reset;
      tick;
      chk("idle no req", {busy, gnt1, gnt0, done1, done0}, 0);

      for (int i = 0; i < 8; i++)
         run_op(tbl[i].r0, tbl[i].r1, tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1,
                tbl[i].ew, tbl[i].ep, $sformatf("vec%0d", i));

      // randomized requests against the model
      do_reset;
      for (int i = 0; i < 40; i++) begin
         r  = int'($urandom_range(1, 3));
         x0 = 8'($urandom); y0 = 8'($urandom); x1 = 8'($urandom); y1 = 8'($urandom);
         w  = pick(r[0], r[1]);
         run_op(r[0], r[1], x0, y0, x1, y1, w, w == 1 ? 16'(x1) * 16'(y1) : 16'(x0) * 16'(y0),
                $sformatf("rnd%0d", i));
      end

      // continuous tie after reset
      do_reset;
      a0 = 8'd3; b0 = 8'd4; a1 = 8'd5; b1 = 8'd6;
      req0 = 1'b1; req1 = 1'b1;
      for (int c = 0; c < 36; c++) begin
         tick;
         if (gnt0 || gnt1) begin gcyc.push_back(c); gwho.push_back(int'(gnt1)); end
         if (done0 || done1) dres.push_back(int'(result));
      end
      req0 = 1'b0; req1 = 1'b0;
      tick;
      chk("tie grant count", gcyc.size(), 4);
      chk("tie done count", dres.size(), 4);
      for (int k = 0; k < gcyc.size() && k < 4; k++) begin
         chk($sformatf("tie grant%0d cycle", k), gcyc[k], 9 * k);
         chk($sformatf("tie grant%0d who", k), gwho[k], k % 2);
      end
      for (int k = 0; k < dres.size() && k < 4; k++)
         chk($sformatf("tie result%0d", k), dres[k], (k % 2) ? 30 : 12);

      // operand change after grant does not disturb the product
      do_reset;
      req0 = 1'b1; a0 = 8'd7; b0 = 8'd9;
      tick;
      req0 = 1'b0;
      chk("stab gnt0", gnt0, 1);
      tick; tick;
      a0 = 8'd99;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         tick;
         if (done0 && seen == 0) begin seen = 1; chk("stab result", result, 63); end
      end
      chk("stab done seen", seen, 1);

      // reset in the 4th MUL cycle aborts the operation
      do_reset;
      req0 = 1'b1; a0 = 8'd20; b0 = 8'd23;
      tick;
      req0 = 1'b0;
      tick; tick; tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("abort busy", busy, 0);
      chk("abort result", result, 0);
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         if (done0 || done1 || busy) cnt++;
         tick;
      end
      chk("abort no done", cnt, 0);
      last_srv = 1;
      run_op(1'b0, 1'b1, 8'd0, 8'd0, 8'd2, 8'd3, 1, 16'd6, "abort then req1");

      // a request pulse during MUL is ignored
      do_reset;
      req0 = 1'b1; a0 = 8'd5; b0 = 8'd5;
      tick;
      req0 = 1'b0;
      tick; tick;
      req1 = 1'b1;
      tick;
      req1 = 1'b0;
      cnt = 0;
      for (int c = 0; c < 16; c++) begin
         if (gnt1) cnt++;
         tick;
      end
      chk("busy block gnt1", cnt, 0);
      chk("busy block result", result, 25);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
